text_buffer: RTL and testbench
==============================

// Module: text_buffer
// PURPOSE
//  Text-mode character store that sits directly upstream of the 8x8 font ROM stage.
//  Holds a COLS x ROWS grid of 8-bit character codes.
//  On the display side it maps the beam position to a character code.
//  It also emits that position delayed to match, so the font stage sees aligned inputs.
//  On the write side a valid/ready stream of bytes is typed at a cursor.
//  The stream supports control codes, line wrap, and scrolling done in hardware.
// PARAMETERS
//  COLS    80   characters per line (640 px / 8)
//  ROWS    60   lines per screen (480 px / 8)
//  BLANK   8'h20  code written by clears; also shown for off-grid positions
// PORTS
//  px_clk      in   1   pixel clock; the only clock
//  rst_n       in   1   asynchronous, active-low reset
//  pos_x       in   10  beam X, pixels
//  pos_y       in   10  beam Y, pixels
//  character   out  8   code of the cell under (pos_x,pos_y), 1 cycle late
//  pos_x_o     out  10  pos_x delayed 1 cycle (feeds font pos_x)
//  pos_y_o     out  10  pos_y delayed 1 cycle (feeds font pos_y)
//  ch_valid    in   1   write-stream byte valid
//  ch_data     in   8   write-stream byte
//  ch_ready    out  1   block accepts ch_data this cycle
//  cursor_col  out  7   current cursor column, 0..COLS-1
//  cursor_row  out  6   current cursor screen row, 0..ROWS-1
// BEHAVIOUR
//  Storage
//   - Dual-port RAM of COLS*ROWS bytes: one write port (FSM) and one registered read port (display).
//   - RAM contents are not reset.
//   - top_row (0..ROWS-1) is a circular offset.
//   - Screen row r is stored at physical row (r + top_row) mod ROWS.
//   - Address = phys_row*COLS + col.
//  Display path, fixed latency 1 cycle
//   - col = pos_x[9:3], row = pos_y[9:3].
//   - If col >= COLS or row >= ROWS, character <= BLANK.
//   - Otherwise character <= RAM[addr]. pos_x_o/pos_y_o are registered in the same cycle.
//   - A same-cycle write to the cell being read returns either the old or the new code.
//     Benches must not check this case.
//  Write FSM states: CLEAR, IDLE, CLRLINE
//   - CLEAR: writes BLANK to every cell, one per cycle, COLS*ROWS cycles. ch_ready=0.
//     Exits to IDLE with cursor=(0,0) and top_row=0.
//   - IDLE: ch_ready=1. A byte is accepted when ch_valid&ch_ready. Actions by code:
//     - 8'h0A (LF): col<=0. If row<ROWS-1, row+1; otherwise perform a SCROLL.
//     - 8'h0D (CR): col<=0.
//     - 8'h08 (BS): if col>0, col-1. Nothing is written.
//     - 8'h0C (FF): go to CLEAR.
//     - Any other code: write the code at the cursor, then col+1.
//       If col==COLS-1, col<=0 and advance the row as for LF (scroll on the last row).
//   - SCROLL: top_row <= (top_row+1) mod ROWS; the cursor stays on row ROWS-1.
//     Go to CLRLINE.
//   - CLRLINE: writes BLANK to the COLS cells of new screen row ROWS-1. ch_ready=0.
//     Lasts COLS cycles, then returns to IDLE.
//   - ch_ready is a registered state decode. It does not depend on ch_valid
//     combinationally. Bytes offered while ch_ready=0 are held by the sender, not dropped.
//  Reset (asynchronous, any time, including mid-CLEAR or mid-CLRLINE)
//   - Outputs: character=BLANK, pos_x_o=0, pos_y_o=0, cursor_col=0, cursor_row=0, ch_ready=0.
//   - Internal: top_row=0. The FSM enters CLEAR, so the screen is blank
//     COLS*ROWS cycles after rst_n rises.
//  Widths
//   - Address is 13 bits (4800 < 8192). Wrap arithmetic is an explicit compare against
//     COLS-1 or ROWS-1, never a power-of-two truncation.
// TESTING
//  1. Release reset, count cycles -> ch_ready rises after exactly 4800 cycles.
//     Every cell then reads 8'h20.
//  2. Send "A" (8'h41) at (0,0), then pos=(0,0) -> next cycle character=8'h41,
//     pos_x_o=0, cursor_col=1.
//  3. pos=(640,0) or (0,480) -> character=8'h20. pos_x_o/pos_y_o track the input with 1-cycle delay.
//  4. Send 80 x 8'h42 from col 0, row 0 -> cursor=(0,1). pos=(632,0) shows 8'h42.
//  5. Cursor on row 59: send "Z" then LF -> top_row=1 and ch_ready=0 for 80 cycles.
//     Then "Z" appears at screen row 58 and row 59 reads 8'h20.
//  6. Assert rst_n=0 mid-CLRLINE -> outputs return to reset values at once,
//     and CLEAR runs in full on release.

Source files
------------

// File: rtl/text_buffer.sv
// -----------------------------------------------------------------------------
// text_buffer
//   Text-mode character store feeding the 8x8 font ROM stage. Holds a
//   COLS x ROWS grid of 8-bit character codes. The display side maps the beam
//   position to a character code with one cycle of latency and re-times the
//   position so the font stage sees aligned inputs. The write side accepts a
//   valid/ready byte stream typed at a cursor, with control codes, line wrap
//   and hardware scrolling (circular top_row offset plus a one-line clear).
//
// Ports
//   px_clk      in   pixel clock, the only clock
//   rst_n       in   asynchronous active-low reset
//   pos_x/pos_y in   beam position in pixels (10 bits each)
//   character   out  code under (pos_x,pos_y), one cycle late; BLANK off-grid
//   pos_x_o     out  pos_x delayed one cycle
//   pos_y_o     out  pos_y delayed one cycle
//   ch_valid    in   write-stream byte valid
//   ch_data     in   write-stream byte
//   ch_ready    out  byte accepted this cycle when ch_valid is also high
//   cursor_col  out  cursor column, 0..COLS-1
//   cursor_row  out  cursor screen row, 0..ROWS-1
// -----------------------------------------------------------------------------
module text_buffer #(
    parameter int          COLS  = 80,
    parameter int          ROWS  = 60,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic [7:0]  character,
    output logic [9:0]  pos_x_o,
    output logic [9:0]  pos_y_o,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    localparam int          CELLS     = COLS * ROWS;
    localparam int          AW        = 13;
    localparam logic [6:0]  COLS7     = 7'(COLS);
    localparam logic [6:0]  ROWS7     = 7'(ROWS);
    localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST  = 6'(ROWS - 1);
    localparam logic [AW-1:0] CELL_LAST = AW'(CELLS - 1);
    localparam logic [AW-1:0] LINE_LAST = AW'(COLS - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, CLRLINE} state_t;

    // Screen row -> physical row through the circular top_row offset. The
    // wrap is an explicit compare because ROWS is not a power of two.
    function automatic logic [AW-1:0] cell_addr(input logic [6:0] scr_row,
                                                input logic [5:0] top,
                                                input logic [6:0] col);
        logic [6:0] sum;
        logic [6:0] phys;
        sum  = scr_row + {1'b0, top};
        phys = (sum >= ROWS7) ? sum - ROWS7 : sum;
        return AW'(phys) * AW'(COLS) + AW'(col);
    endfunction

    logic [7:0]    mem [0:CELLS-1];

    state_t        state_reg, state_next;
    logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
    logic [6:0]    col_reg, col_next;
    logic [5:0]    row_reg, row_next;
    logic [5:0]    top_reg, top_next;
    logic          ch_ready_reg;

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          accept;
    logic          advance_row;

    // Display-side signals
    logic [6:0]    disp_col;
    logic [6:0]    disp_row;
    logic          off_grid;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data_reg;
    logic          off_grid_reg;
    logic [9:0]    pos_x_reg;
    logic [9:0]    pos_y_reg;

    assign accept = ch_valid & ch_ready_reg;

    // ------------------------------------------------------------------
    // Write FSM: next-state and write-port decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        top_next     = top_reg;
        we           = 1'b0;
        waddr        = '0;
        wdata        = BLANK;
        advance_row  = 1'b0;

        case (state_reg)
            CLEAR: begin
                // Physical sweep of the whole array; top_row is irrelevant here.
                we    = 1'b1;
                waddr = clr_cnt_reg;
                if (clr_cnt_reg == CELL_LAST) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end

            IDLE: begin
                if (accept) begin
                    case (ch_data)
                        8'h0A: begin
                            col_next    = '0;
                            advance_row = 1'b1;
                        end
                        8'h0D: col_next = '0;
                        8'h08: begin
                            if (col_reg != '0)
                                col_next = col_reg - 1'b1;
                        end
                        8'h0C: begin
                            state_next   = CLEAR;
                            clr_cnt_next = '0;
                            col_next     = '0;
                            row_next     = '0;
                            top_next     = '0;
                        end
                        default: begin
                            we    = 1'b1;
                            waddr = cell_addr({1'b0, row_reg}, top_reg, col_reg);
                            wdata = ch_data;
                            if (col_reg == COL_LAST) begin
                                col_next    = '0;
                                advance_row = 1'b1;
                            end else begin
                                col_next = col_reg + 1'b1;
                            end
                        end
                    endcase

                    // Shared by LF and by wrap off the last column.
                    if (advance_row) begin
                        if (row_reg != ROW_LAST) begin
                            row_next = row_reg + 1'b1;
                        end else begin
                            top_next     = (top_reg == ROW_LAST) ? '0 : top_reg + 1'b1;
                            state_next   = CLRLINE;
                            clr_cnt_next = '0;
                        end
                    end
                end
            end

            CLRLINE: begin
                // top_reg already holds the new offset, so this targets the
                // line that just scrolled in at the bottom of the screen.
                we    = 1'b1;
                waddr = cell_addr({1'b0, ROW_LAST}, top_reg, clr_cnt_reg[6:0]);
                if (clr_cnt_reg == LINE_LAST) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end

            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            clr_cnt_reg  <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            top_reg      <= '0;
            ch_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            top_reg      <= top_next;
            // Registered decode of the upcoming state keeps ch_ready free of
            // any combinational path from ch_valid.
            ch_ready_reg <= (state_next == IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Display path
    // ------------------------------------------------------------------
    assign disp_col = pos_x[9:3];
    assign disp_row = pos_y[9:3];
    assign off_grid = (disp_col >= COLS7) || (disp_row >= ROWS7);
    // Off-grid reads are steered to address 0; the result is masked anyway.
    assign rd_addr  = off_grid ? '0 : cell_addr(disp_row, top_reg, disp_col);

    // Block RAM: one write port, one registered read port, no reset.
    always_ff @(posedge px_clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_data_reg <= mem[rd_addr];
    end

    // off_grid_reg resets high so character shows BLANK during reset without
    // needing a reset on the RAM output register.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            off_grid_reg <= 1'b1;
            pos_x_reg    <= '0;
            pos_y_reg    <= '0;
        end else begin
            off_grid_reg <= off_grid;
            pos_x_reg    <= pos_x;
            pos_y_reg    <= pos_y;
        end
    end

    assign character  = off_grid_reg ? BLANK : rd_data_reg;
    assign pos_x_o    = pos_x_reg;
    assign pos_y_o    = pos_y_reg;
    assign ch_ready   = ch_ready_reg;
    assign cursor_col = col_reg;
    assign cursor_row = row_reg;

endmodule

// File: tb/tb_text_buffer.sv
// -----------------------------------------------------------------------------
// tb_text_buffer
//   Directed bench for text_buffer: clear timing, display mapping and
//   latency, typing, wrap, scroll with line clear, BS/FF, and reset in the
//   middle of a line clear.
// -----------------------------------------------------------------------------
module tb_text_buffer;

    logic        px_clk;
    logic        rst_n;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [7:0]  character;
    logic [9:0]  pos_x_o;
    logic [9:0]  pos_y_o;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    int vectors;
    int miscompares;

    text_buffer dut (
        .px_clk     (px_clk),
        .rst_n      (rst_n),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .character  (character),
        .pos_x_o    (pos_x_o),
        .pos_y_o    (pos_y_o),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Offer one byte and hold it until accepted (ch_ready only moves on
    // posedges, so sampling it at the negedge is safe).
    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge px_clk);
        ch_valid = 1'b1;
        ch_data  = b;
        while (!ch_ready && k < 10000) begin
            @(negedge px_clk);
            k++;
        end
        if (k >= 10000)
            check("send_stall", 32'(k), 32'd0);
        @(posedge px_clk);
        #1;
        ch_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [9:0] x, input logic [9:0] y,
                             output logic [7:0] c, output logic [9:0] xo,
                             output logic [9:0] yo);
        @(negedge px_clk);
        pos_x = x;
        pos_y = y;
        @(posedge px_clk);
        #1;
        c  = character;
        xo = pos_x_o;
        yo = pos_y_o;
    endtask

    // Cycles from now until ch_ready is seen high, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ch_ready && n < 6000) begin
            n++;
            @(posedge px_clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] c;
        logic [9:0] xo, yo;
        int n, bad;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        pos_x       = 10'd5;
        pos_y       = 10'd9;
        ch_valid    = 1'b0;
        ch_data     = 8'h00;

        repeat (3) @(posedge px_clk);
        #1;
        check("rst_character", 32'(character), 32'h20);
        check("rst_pos_x_o",   32'(pos_x_o),   32'd0);
        check("rst_ready",     32'(ch_ready),  32'd0);
        check("rst_cursor",    32'({cursor_row, cursor_col}), 32'd0);

        // 1. Clear length and blank screen
        @(negedge px_clk);
        pos_x = 10'd0;
        pos_y = 10'd0;
        rst_n = 1'b1;
        wait_ready(n);
        check("clear_len", 32'(n), 32'd4800);
        bad = 0;
        for (int r = 0; r < 60; r++)
            for (int col = 0; col < 80; col++) begin
                read_cell(10'(col * 8), 10'(r * 8), c, xo, yo);
                if (c !== 8'h20) bad++;
            end
        check("blank_all_cells", 32'(bad), 32'd0);

        // 2. Type 'A' at (0,0)
        send(8'h41);
        check("A_cursor_col", 32'(cursor_col), 32'd1);
        read_cell(10'd0, 10'd0, c, xo, yo);
        check("A_char",    32'(c),  32'h41);
        check("A_pos_x_o", 32'(xo), 32'd0);

        // 3. Off-grid and edge positions, delayed position
        read_cell(10'd640, 10'd0, c, xo, yo);
        check("offx_char", 32'(c),  32'h20);
        check("offx_pos_x_o", 32'(xo), 32'd640);
        read_cell(10'd0, 10'd480, c, xo, yo);
        check("offy_char", 32'(c),  32'h20);
        check("offy_pos_y_o", 32'(yo), 32'd480);
        read_cell(10'd639, 10'd479, c, xo, yo);
        check("last_cell_char", 32'(c), 32'h20);
        check("last_cell_pos", 32'({xo, yo}), 32'({10'd639, 10'd479}));

        // 4. Full line of 'B' wraps to next row
        send(8'h0D);
        for (int i = 0; i < 80; i++) send(8'h42);
        check("wrap_cursor", 32'({cursor_row, cursor_col}), 32'({6'd1, 7'd0}));
        read_cell(10'd632, 10'd0, c, xo, yo);
        check("B_col79", 32'(c), 32'h42);
        read_cell(10'd0, 10'd0, c, xo, yo);
        check("B_col0", 32'(c), 32'h42);
        read_cell(10'd0, 10'd8, c, xo, yo);
        check("row1_blank", 32'(c), 32'h20);

        // 5. Scroll from the last row
        for (int i = 0; i < 58; i++) send(8'h0A);
        check("row59_cursor", 32'(cursor_row), 32'd59);
        send(8'h5A);
        send(8'h0A);
        wait_ready(n);
        check("clrline_len", 32'(n), 32'd80);
        check("scroll_cursor", 32'({cursor_row, cursor_col}), 32'({6'd59, 7'd0}));
        read_cell(10'd0, 10'd464, c, xo, yo);
        check("Z_row58", 32'(c), 32'h5A);
        read_cell(10'd0, 10'd472, c, xo, yo);
        check("row59_col0_blank", 32'(c), 32'h20);
        read_cell(10'd632, 10'd472, c, xo, yo);
        check("row59_col79_blank", 32'(c), 32'h20);
        read_cell(10'd0, 10'd0, c, xo, yo);
        check("row0_after_scroll", 32'(c), 32'h20);

        // Backspace and overwrite, BS at column 0
        send(8'h50);
        send(8'h08);
        check("bs_cursor", 32'(cursor_col), 32'd0);
        send(8'h08);
        check("bs_at_col0", 32'(cursor_col), 32'd0);
        send(8'h51);
        read_cell(10'd0, 10'd472, c, xo, yo);
        check("overwrite_Q", 32'(c), 32'h51);
        read_cell(10'd8, 10'd472, c, xo, yo);
        check("bs_no_write", 32'(c), 32'h20);

        // 6. Reset in the middle of a line clear
        send(8'h0A);
        check("clrline_ready_low", 32'(ch_ready), 32'd0);
        repeat (20) @(posedge px_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_character", 32'(character), 32'h20);
        check("midrst_pos_x_o",   32'(pos_x_o),   32'd0);
        check("midrst_pos_y_o",   32'(pos_y_o),   32'd0);
        check("midrst_cursor",    32'({cursor_row, cursor_col}), 32'd0);
        check("midrst_ready",     32'(ch_ready),  32'd0);
        repeat (2) @(posedge px_clk);
        @(negedge px_clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("reclear_len", 32'(n), 32'd4800);
        read_cell(10'd0, 10'd464, c, xo, yo);
        check("Z_cleared", 32'(c), 32'h20);

        // Form feed clears the screen again
        send(8'h4B);
        read_cell(10'd0, 10'd0, c, xo, yo);
        check("K_char", 32'(c), 32'h4B);
        send(8'h0C);
        wait_ready(n);
        check("ff_clear_len", 32'(n), 32'd4800);
        check("ff_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        read_cell(10'd0, 10'd0, c, xo, yo);
        check("ff_cell_blank", 32'(c), 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
